// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate-extension pipeline stage.
// Holds the mode encodings and the occupancy states of the two-entry skid buffer.
package imm_ext_pkg;

  typedef enum logic [1:0] {
    IMM_ZERO     = 2'b00,
    IMM_SIGN     = 2'b01,
    IMM_SIGN_SHL = 2'b10,
    IMM_RSVD     = 2'b11
  } imm_mode_e;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_FULL  = 2'b10
  } occ_e;

  localparam int CNT_W = 16;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: zero-extend, sign-extend, or sign-extend then shift left.
// The reserved mode yields a zero value with err raised.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16,
  parameter int SHIFT = 1
) (
  input  logic [IN_W-1:0]  data,
  input  logic [1:0]       mode,
  output logic [OUT_W-1:0] value,
  output logic             err
);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  // Size casts handle IN_W == OUT_W without a zero-width replication.
  assign zext = OUT_W'(data);
  assign sext = OUT_W'(signed'(data));

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    value = '0;
    err   = 1'b0;
    case (imm_mode_e'(mode))
      IMM_ZERO:     value = zext;
      IMM_SIGN:     value = sext;
      IMM_SIGN_SHL: value = sext << SHIFT;
      default:      err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered, handshaked immediate-extension stage with a two-entry skid buffer.
// Optional output transfer counter xfer_cnt is built when IMM_EXT_CNT_EN is defined.
module imm_extend_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = 16,
  parameter int SHIFT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err
`ifdef IMM_EXT_CNT_EN
  ,
  output logic [CNT_W-1:0] xfer_cnt
`endif
);

  occ_e             state_q, state_d;
  logic             in_ready_q, out_valid_q;
  logic [OUT_W-1:0] m_data_q, s_data_q;
  logic             m_err_q, s_err_q;
  logic [OUT_W-1:0] ext_value;
  logic             ext_err;
  logic             in_xfer, out_xfer;
  logic             load_m_in, load_m_skid, load_s;

  imm_ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .SHIFT (SHIFT)
  ) u_core (
    .data  (in_data),
    .mode  (in_mode),
    .value (ext_value),
    .err   (ext_err)
  );

  assign in_xfer  = in_valid & in_ready_q;
  assign out_xfer = out_valid_q & out_ready;

  always_comb begin
    state_d     = state_q;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    case (state_q)
      OCC_EMPTY: begin
        if (in_xfer) begin
          state_d   = OCC_ONE;
          load_m_in = 1'b1;
        end
      end
      OCC_ONE: begin
        if (in_xfer && out_xfer) begin
          load_m_in = 1'b1;
        end else if (in_xfer) begin
          state_d = OCC_FULL;
          load_s  = 1'b1;
        end else if (out_xfer) begin
          state_d = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (out_xfer) begin
          state_d     = OCC_ONE;
          load_m_skid = 1'b1;
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  // Handshake flags are registered copies of the next occupancy, so in_ready
  // never has a combinational path from out_ready.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= OCC_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != OCC_FULL);
      out_valid_q <= (state_d != OCC_EMPTY);
    end
  end

  // NOTE: data registers are reset too, because out_data must read zero out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_data_q <= '0;
      m_err_q  <= 1'b0;
      s_data_q <= '0;
      s_err_q  <= 1'b0;
    end else begin
      if (load_m_in) begin
        m_data_q <= ext_value;
        m_err_q  <= ext_err;
      end else if (load_m_skid) begin
        m_data_q <= s_data_q;
        m_err_q  <= s_err_q;
      end
      if (load_s) begin
        s_data_q <= ext_value;
        s_err_q  <= ext_err;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = m_data_q;
  assign out_err   = m_err_q;

`ifdef IMM_EXT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Free-running wrap at all-ones; reserved-mode beats are counted like any other.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (out_xfer) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign xfer_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed self-checking bench for imm_extend_pipe (IN_W=9, OUT_W=16, SHIFT=1).
// Counter checks are compiled in when IMM_EXT_CNT_EN is defined.
module tb_imm_extend_pipe;
  import imm_ext_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  in_data;
  logic [1:0]  in_mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;
`ifdef IMM_EXT_CNT_EN
  logic [15:0] xfer_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  imm_extend_pipe #(
    .IN_W  (9),
    .OUT_W (16),
    .SHIFT (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
`ifdef IMM_EXT_CNT_EN
    ,
    .xfer_cnt  (xfer_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat into an empty stage with out_ready=1: visible one cycle later, gone the next.
  task automatic send_one(input string tag, input logic [8:0] d, input logic [1:0] m,
                          input logic [15:0] exp_v, input logic exp_e);
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    check({tag, "_rdy"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    in_data  = 'x;
    in_mode  = 'x;
    check({tag, "_vld"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(exp_v));
    check({tag, "_err"}, 32'(out_err), 32'(exp_e));
    tick();
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 'x;
    in_mode   = 'x;
    out_ready = 1'b1;

    // Reset held, then released
    repeat (3) tick();
    check("rst_vld",  32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data),  32'h0000);
    check("rst_rdy",  32'(in_ready),  32'd1);
    check("rst_err",  32'(out_err),   32'd0);
    rst = 1'b1;
    tick();
    check("post_rst_vld", 32'(out_valid), 32'd0);
    check("post_rst_rdy", 32'(in_ready),  32'd1);

    // Extension of 9'h100 and 9'h0FF across all modes
    send_one("sext_100", 9'h100, IMM_SIGN,     16'hFF00, 1'b0);
    send_one("zext_100", 9'h100, IMM_ZERO,     16'h0100, 1'b0);
    send_one("shl_100",  9'h100, IMM_SIGN_SHL, 16'hFE00, 1'b0);
    send_one("sext_0ff", 9'h0FF, IMM_SIGN,     16'h00FF, 1'b0);
    send_one("shl_0ff",  9'h0FF, IMM_SIGN_SHL, 16'h01FE, 1'b0);
    send_one("rsvd_0ff", 9'h0FF, IMM_RSVD,     16'h0000, 1'b1);
    send_one("err_clr",  9'h001, IMM_ZERO,     16'h0001, 1'b0);

    // Backpressure: A and B accepted, C held off until space frees up
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 9'h001;
    in_mode   = IMM_ZERO;
    tick();
    check("bp_a_rdy", 32'(in_ready), 32'd1);
    in_data = 9'h002;
    tick();
    check("bp_full_rdy", 32'(in_ready), 32'd0);
    check("bp_a_data",   32'(out_data), 32'h0001);
    in_data = 9'h003;
    tick();
    check("bp_hold_rdy",  32'(in_ready),  32'd0);
    check("bp_hold_vld",  32'(out_valid), 32'd1);
    check("bp_hold_data", 32'(out_data),  32'h0001);
    out_ready = 1'b1;
    tick();
    check("bp_b_data", 32'(out_data), 32'h0002);
    check("bp_b_rdy",  32'(in_ready), 32'd1);
    tick();
    check("bp_c_data", 32'(out_data),  32'h0003);
    check("bp_c_vld",  32'(out_valid), 32'd1);
    in_valid = 1'b0;
    in_data  = 'x;
    in_mode  = 'x;
    tick();
    check("bp_drain", 32'(out_valid), 32'd0);

    // Streaming: one beat per cycle, in_ready never drops
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_data  = 9'(i * 7 + 1);
      in_mode  = IMM_ZERO;
      tick();
      check($sformatf("str_vld_%0d", i),  32'(out_valid), 32'd1);
      check($sformatf("str_data_%0d", i), 32'(out_data),  32'(i * 7 + 1));
      check($sformatf("str_rdy_%0d", i),  32'(in_ready),  32'd1);
    end
    in_valid = 1'b0;
    in_data  = 'x;
    in_mode  = 'x;
    tick();
    check("str_drain", 32'(out_valid), 32'd0);

    // Reset pulsed mid-stream with both entries occupied, away from any clock edge
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 9'h055;
    in_mode   = IMM_SIGN;
    tick();
    tick();
    check("mid_full_vld", 32'(out_valid), 32'd1);
    check("mid_full_rdy", 32'(in_ready),  32'd0);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_vld",  32'(out_valid), 32'd0);
    check("mid_rst_rdy",  32'(in_ready),  32'd1);
    check("mid_rst_data", 32'(out_data),  32'h0000);
    in_valid  = 1'b0;
    in_data   = 'x;
    in_mode   = 'x;
    out_ready = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("mid_post_vld", 32'(out_valid), 32'd0);

`ifdef IMM_EXT_CNT_EN
    // Transfer counter: five beats, then run up to all-ones and wrap
    check("cnt_rst", 32'(xfer_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      send_one($sformatf("cnt_beat_%0d", i), 9'(i), (i == 4) ? IMM_RSVD : IMM_ZERO,
               (i == 4) ? 16'h0000 : 16'(i), (i == 4) ? 1'b1 : 1'b0);
    end
    check("cnt_five", 32'(xfer_cnt), 32'd5);
    in_valid = 1'b1;
    in_data  = 9'h000;
    in_mode  = IMM_ZERO;
    repeat (65530) tick();
    in_valid = 1'b0;
    in_data  = 'x;
    in_mode  = 'x;
    tick();
    check("cnt_max", 32'(xfer_cnt), 32'hFFFF);
    send_one("cnt_wrap_beat", 9'h002, IMM_ZERO, 16'h0002, 1'b0);
    check("cnt_wrap", 32'(xfer_cnt), 32'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
